// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - MemOP encodings, LSU FSM states and size decode shared by the LSU files
// LSU_MISALIGN_SPLIT_EN adds the second-beat states.
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_W  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_WAIT0,
`ifdef LSU_MISALIGN_SPLIT_EN
    ST_BEAT1,
    ST_WAIT1,
`endif
    ST_RESP
  } lsu_state_e;

  // Access size in bytes; 0 marks the unused size code.
  function automatic logic [2:0] memop_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic memop_legal(input logic [2:0] op);
    return (op[1:0] != 2'b11) && !(op[2] && op[1]);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response and memory-beat bundles for the LSU
// The LSU is the slave of the request bus and the master of the memory bus.
interface lsu_req_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_memop;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_memop, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_memop, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_rvalid
  );
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane shift/strobes and load byte merge/extension
// Both directions view the access as a 64-bit window over two consecutive words.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_off,
  input  logic        i_beat1,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);
  logic [2:0]  w_size;
  logic [63:0] w_st_sh;
  logic [7:0]  w_mask;
  logic [7:0]  w_strb;
  logic [31:0] w_ld_raw;

  assign w_size  = memop_size(i_memop);
  assign w_st_sh = {32'd0, i_wdata} << {i_off, 3'b000};

  always_comb begin
    w_mask = 8'h00;
    case (w_size)
      3'd1:    w_mask = 8'h01;
      3'd2:    w_mask = 8'h03;
      3'd4:    w_mask = 8'h0F;
      default: w_mask = 8'h00;
    endcase
  end

  assign w_strb  = w_mask << i_off;
  assign o_wdata = i_beat1 ? w_st_sh[63:32] : w_st_sh[31:0];
  assign o_wstrb = i_beat1 ? w_strb[7:4] : w_strb[3:0];

  // Low word holds lanes addr[1:0]..3, high word continues the access.
  assign w_ld_raw = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  always_comb begin
    o_rdata = w_ld_raw;
    case (w_size)
      3'd1:    o_rdata = {{24{w_ld_raw[7] & ~i_memop[2]}}, w_ld_raw[7:0]};
      3'd2:    o_rdata = {{16{w_ld_raw[15] & ~i_memop[2]}}, w_ld_raw[15:0]};
      default: o_rdata = w_ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store control FSM between execute stage and byte-strobed data memory
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats instead of faulting.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic       clk,
  input logic       rst,
  lsu_req_if.slave  req_bus,
  lsu_mem_if.master mem_bus
);
  lsu_state_e    r_state;
  logic          r_we;
  logic [2:0]    r_op;
  logic [1:0]    r_off;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_lo;
  logic          r_mem_valid;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [3:0]    r_mem_wstrb;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [DW-1:0] r_resp_rdata;

  logic          w_idle;
  logic [2:0]    w_op;
  logic [2:0]    w_size;
  logic [1:0]    w_off;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_lo;
  logic [DW-1:0] w_st_wdata;
  logic [3:0]    w_st_wstrb;
  logic [DW-1:0] w_ld_data;
  logic          w_beat1;
  logic          w_bad;

  // In IDLE the aligner looks at the incoming request so beat 0 can launch on accept.
  assign w_idle  = (r_state == ST_IDLE);
  assign w_op    = w_idle ? req_bus.req_memop     : r_op;
  assign w_off   = w_idle ? req_bus.req_addr[1:0] : r_off;
  assign w_wdata = w_idle ? req_bus.req_wdata     : r_wdata;
  assign w_lo    = (r_state == ST_WAIT0) ? mem_bus.mem_rdata : r_lo;
  assign w_size  = memop_size(w_op);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic          r_split;
  logic [AW-3:0] r_word;
  logic          w_split;
  logic [AW-3:0] w_word_next;

  assign w_split     = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_word_next = r_word + (AW-2)'(1);
  assign w_beat1     = !w_idle;
  assign w_bad       = !memop_legal(w_op);
`else
  assign w_beat1 = 1'b0;
  assign w_bad   = !memop_legal(w_op) || (w_size == 3'd2 && w_off[0]) ||
                   (w_size == 3'd4 && w_off != 2'b00);
`endif

  lsu_lane_align u_align (
    .i_memop (w_op),
    .i_off   (w_off),
    .i_beat1 (w_beat1),
    .i_wdata (w_wdata),
    .i_lo    (w_lo),
    .i_hi    (mem_bus.mem_rdata),
    .o_wdata (w_st_wdata),
    .o_wstrb (w_st_wstrb),
    .o_rdata (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_op         <= 3'd0;
      r_off        <= 2'd0;
      r_wdata      <= '0;
      r_lo         <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split      <= 1'b0;
      r_word       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (req_bus.req_valid) begin
          r_we    <= req_bus.req_we;
          r_op    <= req_bus.req_memop;
          r_off   <= req_bus.req_addr[1:0];
          r_wdata <= req_bus.req_wdata;
          r_lo    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          r_split <= w_split;
          r_word  <= req_bus.req_addr[AW-1:2];
`endif
          if (w_bad) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= req_bus.req_we;
            r_mem_addr  <= {req_bus.req_addr[AW-1:2], 2'b00};
            r_mem_wdata <= req_bus.req_we ? w_st_wdata : '0;
            r_mem_wstrb <= req_bus.req_we ? w_st_wstrb : 4'd0;
            r_state     <= ST_BEAT0;
          end
        end
        ST_BEAT0: if (mem_bus.mem_ready) begin
          r_mem_valid <= 1'b0;
          if (!r_we) begin
            r_state <= ST_WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (r_split) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {w_word_next, 2'b00};
            r_mem_wdata <= w_st_wdata;
            r_mem_wstrb <= w_st_wstrb;
            r_state     <= ST_BEAT1;
`endif
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end
        end
        ST_WAIT0: if (mem_bus.mem_rvalid) begin
          r_lo <= mem_bus.mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_split) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {w_word_next, 2'b00};
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'd0;
            r_state     <= ST_BEAT1;
          end else
`endif
          begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_ld_data;
            r_state      <= ST_RESP;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_BEAT1: if (mem_bus.mem_ready) begin
          r_mem_valid <= 1'b0;
          if (!r_we) begin
            r_state <= ST_WAIT1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end
        end
        ST_WAIT1: if (mem_bus.mem_rvalid) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_ld_data;
          r_state      <= ST_RESP;
        end
`endif
        ST_RESP: if (req_bus.resp_ready) begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_bus.req_ready  = w_idle;
  assign req_bus.resp_valid = r_resp_valid;
  assign req_bus.resp_err   = r_resp_err;
  assign req_bus.resp_rdata = r_resp_rdata;
  assign mem_bus.mem_valid  = r_mem_valid;
  assign mem_bus.mem_we     = r_mem_we;
  assign mem_bus.mem_addr   = r_mem_addr;
  assign mem_bus.mem_wdata  = r_mem_wdata;
  assign mem_bus.mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_req_if rb ();
  lsu_mem_if mb ();

  lsu_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req_bus (rb),
    .mem_bus (mb)
  );

  logic [31:0] mem [0:255];
  beat_t       beats[$];
  int          rd_lat   = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_data;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory: logs accepted beats, applies store strobes, returns read data rd_lat cycles later.
  always @(posedge clk) begin
    beat_t b;
    if (pend_cnt != 0) pend_cnt--;
    if (mb.mem_valid && mb.mem_ready) begin
      b.we = mb.mem_we; b.addr = mb.mem_addr; b.wdata = mb.mem_wdata; b.strb = mb.mem_wstrb;
      beats.push_back(b);
      if (mb.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mb.mem_wstrb[i]) mem[mb.mem_addr[9:2]][8*i +: 8] = mb.mem_wdata[8*i +: 8];
      end else begin
        pend_cnt  = rd_lat;
        pend_data = mem[mb.mem_addr[9:2]];
      end
    end
    #1;
    mb.mem_rvalid = (pend_cnt == 1);
    mb.mem_rdata  = (pend_cnt == 1) ? pend_data : 32'h0;
  end

  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int guard;
    guard = 0;
    beats.delete();
    rb.req_we = we; rb.req_memop = op; rb.req_addr = addr; rb.req_wdata = wdata;
    rb.req_valid = 1'b1;
    while (!rb.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    if (guard >= 20) chk("req_accept_timeout", 32'(rb.req_ready), 32'd1);
    @(posedge clk); #1;
    rb.req_valid = 1'b0;
    lat = 1;
    while (!rb.resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rb.resp_valid) chk("resp_timeout", 32'(rb.resp_valid), 32'd1);
    rdata = rb.resp_rdata;
    err   = rb.resp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;

    rst = 1'b1;
    rb.req_valid = 1'b0; rb.req_we = 1'b0; rb.req_memop = 3'd0;
    rb.req_addr = 32'h0; rb.req_wdata = 32'h0; rb.resp_ready = 1'b1;
    mb.mem_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(rb.req_ready), 32'd1);
    chk("rst_ctrl_outs", 32'({mb.mem_valid, mb.mem_we, mb.mem_wstrb, rb.resp_valid, rb.resp_err}), 32'h0);
    chk("rst_mem_addr", mb.mem_addr, 32'h0);
    chk("rst_mem_wdata", mb.mem_wdata, 32'h0);
    chk("rst_resp_rdata", rb.resp_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Aligned word load
    mem[64] = 32'hDEADBEEF;
    do_req(1'b0, MEMOP_W, 32'h100, 32'h0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_latency", lat, 3);
    chk("lw_nbeats", beats.size(), 1);
    if (beats.size() == 1) begin
      chk("lw_beat_addr", beats[0].addr, 32'h100);
      chk("lw_beat_we_strb", 32'({beats[0].we, beats[0].strb}), 32'h0);
    end
    chk("lw_back_idle", 32'({rb.resp_valid, rb.req_ready}), 32'h1);

    // Byte loads with sign and zero extension
    mem[64] = 32'h80112233;
    do_req(1'b0, MEMOP_B, 32'h103, 32'h0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    do_req(1'b0, MEMOP_BU, 32'h103, 32'h0, rd, er, lat);
    chk("lbu_zero", rd, 32'h00000080);
    do_req(1'b0, MEMOP_H, 32'h102, 32'h0, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFF8011);
    do_req(1'b0, MEMOP_HU, 32'h100, 32'h0, rd, er, lat);
    chk("lhu_low", rd, 32'h00002233);

    // Half store into upper lanes
    do_req(1'b1, MEMOP_H, 32'h102, 32'h0000ABCD, rd, er, lat);
    chk("sh_rdata", rd, 32'h0);
    chk("sh_err", 32'(er), 32'd0);
    chk("sh_latency", lat, 2);
    chk("sh_nbeats", beats.size(), 1);
    if (beats.size() == 1) begin
      chk("sh_beat_addr", beats[0].addr, 32'h100);
      chk("sh_beat_we_strb", 32'({beats[0].we, beats[0].strb}), 32'h1C);
      chk("sh_beat_wdata_hi", 32'(beats[0].wdata[31:16]), 32'hABCD);
    end
    chk("sh_mem_word", mem[64], 32'hABCD2233);

    // Word-crossing load and store, and a misaligned half inside one word
    mem[63] = 32'h3344AAAA;
    mem[64] = 32'hBBBB1122;
    do_req(1'b0, MEMOP_W, 32'h0FE, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("split_lw_rdata", rd, 32'h11223344);
    chk("split_lw_err", 32'(er), 32'd0);
    chk("split_lw_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("split_lw_addr0", beats[0].addr, 32'h0FC);
      chk("split_lw_addr1", beats[1].addr, 32'h100);
    end
`else
    chk("mis_lw_err", 32'(er), 32'd1);
    chk("mis_lw_rdata", rd, 32'h0);
    chk("mis_lw_nbeats", beats.size(), 0);
`endif
    do_req(1'b1, MEMOP_W, 32'h0FE, 32'h11223344, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("split_sw_err", 32'(er), 32'd0);
    chk("split_sw_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("split_sw_strb0", 32'(beats[0].strb), 32'hC);
      chk("split_sw_strb1", 32'(beats[1].strb), 32'h3);
      chk("split_sw_addr1", beats[1].addr, 32'h100);
    end
    chk("split_sw_mem_lo", mem[63], 32'h3344AAAA);
    chk("split_sw_mem_hi", mem[64], 32'hBBBB1122);
`else
    chk("mis_sw_err", 32'(er), 32'd1);
    chk("mis_sw_nbeats", beats.size(), 0);
`endif
    mem[64] = 32'h00C0FF00;
    do_req(1'b0, MEMOP_HU, 32'h101, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("mid_lhu_rdata", rd, 32'h0000C0FF);
    chk("mid_lhu_nbeats", beats.size(), 1);
`else
    chk("mid_lhu_err", 32'(er), 32'd1);
    chk("mid_lhu_nbeats", beats.size(), 0);
`endif

    // Backpressure on the memory beat, then on the response
    mb.mem_ready = 1'b0;
    rb.resp_ready = 1'b0;
    beats.delete();
    rb.req_we = 1'b1; rb.req_memop = MEMOP_B; rb.req_addr = 32'h101; rb.req_wdata = 32'h5A;
    rb.req_valid = 1'b1;
    @(posedge clk); #1;
    rb.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_mem_addr", mb.mem_addr, 32'h100);
      chk("bp_valid_strb", 32'({mb.mem_valid, mb.mem_wstrb}), 32'h12);
      chk("bp_mem_wdata", mb.mem_wdata, 32'h00005A00);
      @(posedge clk); #1;
    end
    mb.mem_ready = 1'b1;
    guard = 0;
    while (!rb.resp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    if (!rb.resp_valid) chk("bp_resp_timeout", 32'(rb.resp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_resp_hold", 32'({rb.resp_valid, rb.req_ready, rb.resp_err}), 32'h4);
      chk("bp_resp_rdata", rb.resp_rdata, 32'h0);
      @(posedge clk); #1;
    end
    rb.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 32'({rb.resp_valid, rb.req_ready}), 32'h1);
    chk("bp_nbeats", beats.size(), 1);

    // Reset while waiting for read data; the late rvalid must be dropped
    rd_lat = 2;
    mem[64] = 32'hDEADBEEF;
    rb.req_we = 1'b0; rb.req_memop = MEMOP_W; rb.req_addr = 32'h100; rb.req_wdata = 32'h0;
    rb.req_valid = 1'b1;
    @(posedge clk); #1;
    rb.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait0_no_beat", 32'({mb.mem_valid, rb.resp_valid, rb.req_ready}), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req_ready", 32'(rb.req_ready), 32'd1);
    chk("midrst_outs", 32'({mb.mem_valid, mb.mem_we, mb.mem_wstrb, rb.resp_valid, rb.resp_err}), 32'h0);
    chk("midrst_addr", mb.mem_addr, 32'h0);
    @(posedge clk); #1;
    chk("late_rvalid_dropped", 32'({rb.resp_valid, rb.req_ready, mb.mem_valid}), 32'h2);
    chk("late_rdata_zero", rb.resp_rdata, 32'h0);
    rd_lat = 1;
    do_req(1'b0, MEMOP_W, 32'h100, 32'h0, rd, er, lat);
    chk("post_rst_lw", rd, 32'hDEADBEEF);

    // Unsupported memops fault without touching memory
    do_req(1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat);
    chk("ill_011_err", 32'(er), 32'd1);
    chk("ill_011_rdata", rd, 32'h0);
    chk("ill_011_nbeats", beats.size(), 0);
    do_req(1'b1, 3'b110, 32'h100, 32'h12345678, rd, er, lat);
    chk("ill_110_err", 32'(er), 32'd1);
    chk("ill_110_nbeats", beats.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
